conv_if_window_gen: RTL and testbench

Upstream feeder for `castlab_ws_systolic_array`. It accepts a raster-order stream of input-feature pixels, one pixel (all channels) per beat. It buffers two rows in on-chip line buffers and emits one zero-padded 3x3xIF_CHANNEL window per cycle on the array's `if_i_data` / `if_i_valid` bus. It produces exactly one window per output pixel (same-size convolution, stride 1) and pulses `o_done` at frame end.

---
 rtl/conv_if_window_gen_if.sv | 38 +++
 rtl/conv_if_window_gen.sv | 174 +++++++++++++++++
 tb/tb_conv_if_window_gen.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_if_window_gen_if.sv
// Pixel-in / window-out bus between the raster feeder, the window generator
// and the systolic array input.
interface conv_if_window_gen_if #(
    parameter int IF_CHANNEL  = 3,
    parameter int IF_BITWIDTH = 16,
    parameter int IF_PORT     = 27
);
    logic                                   start;
    logic [IF_CHANNEL-1:0][IF_BITWIDTH-1:0] i_data;
    logic                                   i_valid;
    logic                                   i_ready;
    logic [IF_PORT-1:0][IF_BITWIDTH-1:0]    o_data;
    logic [IF_PORT-1:0]                     o_valid;
    logic                                   o_done;
    logic                                   busy;

    modport master (
        output start,
        output i_data,
        output i_valid,
        input  i_ready,
        input  o_data,
        input  o_valid,
        input  o_done,
        input  busy
    );

    modport slave (
        input  start,
        input  i_data,
        input  i_valid,
        output i_ready,
        output o_data,
        output o_valid,
        output o_done,
        output busy
    );
endinterface

// File: rtl/conv_if_window_gen.sv
// Raster pixel stream to zero-padded 3x3xC windows, one per output pixel,
// using two line buffers and a 3x3 shifting window register.
module conv_if_window_gen #(
    parameter int IF_WIDTH    = 128,
    parameter int IF_HEIGHT   = 128,
    parameter int IF_CHANNEL  = 3,
    parameter int IF_BITWIDTH = 16,
    parameter int K_WIDTH     = 3,
    parameter int K_HEIGHT    = 3,
    parameter int IF_PORT     = 27
) (
    input logic                clk,
    input logic                rst_n,
    conv_if_window_gen_if.slave bus
);
    localparam int PW = IF_CHANNEL * IF_BITWIDTH;
    localparam int CW = $clog2(IF_WIDTH);
    localparam int RW = $clog2(IF_HEIGHT + 2);

    if (K_WIDTH != 3 || K_HEIGHT != 3 ||
        IF_PORT != IF_CHANNEL * K_WIDTH * K_HEIGHT) begin : g_bad_cfg
        $error("conv_if_window_gen: only 3x3 kernels supported");
    end

    typedef logic [PW-1:0] pix_t;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] in_c;
    logic [RW-1:0] in_r;
    logic [CW-1:0] out_c;
    logic [RW-1:0] out_r;

    pix_t lb0 [IF_WIDTH];
    pix_t lb1 [IF_WIDTH];
    pix_t win     [3][3];
    pix_t win_nxt [3][3];

    pix_t pix_in;
    pix_t tap_mid;
    pix_t tap_top;

    logic step;
    logic emit;
    logic last_in;
    logic last_out;

    logic [IF_PORT-1:0][IF_BITWIDTH-1:0] o_data_q;
    logic [IF_PORT-1:0][IF_BITWIDTH-1:0] o_data_nxt;
    logic [IF_PORT-1:0]                  o_valid_q;
    logic                                o_done_q;

    assign bus.i_ready = (state == RUN);
    assign bus.busy    = (state != IDLE);
    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_done  = o_done_q;

    // FLUSH keeps stepping with zero pixels so the last row drains.
    always_comb begin
        pix_in  = (state == RUN) ? pix_t'(bus.i_data) : '0;
        tap_mid = lb0[in_c];
        tap_top = lb1[in_c];
        step    = ((state == RUN) && bus.i_valid) || (state == FLUSH);
        // Window k leaves when the step index reaches k + W + 1.
        emit    = step && ((in_r > RW'(1)) ||
                  ((in_r == RW'(1)) && (in_c != '0)));
        last_in  = (in_r == RW'(IF_HEIGHT - 1)) &&
                   (in_c == CW'(IF_WIDTH - 1));
        last_out = (out_r == RW'(IF_HEIGHT - 1)) &&
                   (out_c == CW'(IF_WIDTH - 1));
    end

    always_comb begin
        for (int y = 0; y < 3; y++) begin
            win_nxt[y][0] = win[y][1];
            win_nxt[y][1] = win[y][2];
        end
        win_nxt[0][2] = tap_top;
        win_nxt[1][2] = tap_mid;
        win_nxt[2][2] = pix_in;
    end

    for (genvar p = 0; p < IF_PORT; p++) begin : g_port
        localparam int CH = p / 9;
        localparam int KY = (p % 9) / 3;
        localparam int KX = p % 3;
        logic row_ok;
        logic col_ok;

        assign row_ok = (KY == 0) ? (out_r != '0) :
                        (KY == 2) ? (out_r != RW'(IF_HEIGHT - 1)) :
                        1'b1;
        assign col_ok = (KX == 0) ? (out_c != '0) :
                        (KX == 2) ? (out_c != CW'(IF_WIDTH - 1)) :
                        1'b1;
        assign o_data_nxt[p] = (row_ok && col_ok) ?
            win_nxt[KY][KX][CH*IF_BITWIDTH +: IF_BITWIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (step && last_in) state_nxt = FLUSH;
            FLUSH:   if (emit && last_out) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is left uninitialised; out-of-frame taps are masked.
    always_ff @(posedge clk) begin
        if (step) begin
            lb0[in_c] <= pix_in;
            lb1[in_c] <= tap_mid;
            win       <= win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_c      <= '0;
            in_r      <= '0;
            out_c     <= '0;
            out_r     <= '0;
            o_data_q  <= '0;
            o_valid_q <= '0;
            o_done_q  <= 1'b0;
        end else begin
            o_valid_q <= {IF_PORT{emit}};
            o_done_q  <= (state == DONE);
            if ((state == IDLE) && bus.start) begin
                in_c  <= '0;
                in_r  <= '0;
                out_c <= '0;
                out_r <= '0;
            end else begin
                if (step) begin
                    if (in_c == CW'(IF_WIDTH - 1)) begin
                        in_c <= '0;
                        in_r <= in_r + 1'b1;
                    end else begin
                        in_c <= in_c + 1'b1;
                    end
                end
                if (emit) begin
                    o_data_q <= o_data_nxt;
                    if (out_c == CW'(IF_WIDTH - 1)) begin
                        out_c <= '0;
                        out_r <= out_r + 1'b1;
                    end else begin
                        out_c <= out_c + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_if_window_gen.sv
// Directed 4x4x3 frames against hand-derived padded windows, plus timing,
// mid-frame start and mid-frame reset cases.
module tb_conv_if_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int C = 3;
    localparam int B = 16;
    localparam int P = 27;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    conv_if_window_gen_if #(
        .IF_CHANNEL (C),
        .IF_BITWIDTH(B),
        .IF_PORT    (P)
    ) bus ();

    conv_if_window_gen #(
        .IF_WIDTH   (W),
        .IF_HEIGHT  (H),
        .IF_CHANNEL (C),
        .IF_BITWIDTH(B),
        .K_WIDTH    (3),
        .K_HEIGHT   (3),
        .IF_PORT    (P)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int wcount;
    int done_cnt;
    int last_val;
    int last_xfer;
    int done_cyc;
    int ov_bad;
    logic [B-1:0] win [N][P];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_tap(input int r, input int c, input int p);
        int ch;
        int rr;
        int cc;
        ch = p / 9;
        rr = r + (p % 9) / 3 - 1;
        cc = c + p % 3 - 1;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 0;
        return rr * 16 + cc * 4 + ch;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.i_valid && bus.i_ready) last_xfer = cyc;
        if (bus.o_valid != '0 && bus.o_valid != '1) ov_bad = 1;
        if (bus.o_valid[0]) begin
            if (wcount < N)
                for (int p = 0; p < P; p++) win[wcount][p] = bus.o_data[p];
            wcount++;
            last_val = cyc;
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        wcount    = 0;
        done_cnt  = 0;
        last_val  = 0;
        last_xfer = 0;
        done_cyc  = 0;
        ov_bad    = 0;
    endtask

    task automatic set_pix(input int n);
        for (int ch = 0; ch < C; ch++)
            bus.i_data[ch] = B'((n / W) * 16 + (n % W) * 4 + ch);
    endtask

    // Feeds `count` pixels; start is re-pulsed alongside pixel start_at.
    task automatic feed(input bit gappy, input int start_at, input int count);
        int n;
        int guard;
        n = 0;
        guard = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("ready_after_start", int'(bus.i_ready), 1);
        chk("busy_after_start", int'(bus.busy), 1);
        while (n < count && guard < 400) begin
            guard++;
            bus.i_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            set_pix(n);
            if (n == start_at && bus.i_valid) bus.start = 1'b1;
            @(posedge clk);
            if (bus.i_valid) n++;
            #1;
            bus.start   = 1'b0;
            bus.i_valid = 1'b0;
        end
        chk("feed_count", n, count);
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (done_cnt == 0 && i < 60) begin
            @(posedge clk);
            i++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_win_count"}, wcount, N);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_lag"}, done_cyc - last_val, 1);
        chk({tag, "_flush_len"}, last_val - last_xfer, W + 2);
        chk({tag, "_ovalid_uniform"}, ov_bad, 0);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
        chk({tag, "_ready_end"}, int'(bus.i_ready), 0);
        for (int k = 0; k < N; k++)
            for (int p = 0; p < P; p++)
                chk($sformatf("%s_w%0d_p%0d", tag, k, p),
                    int'(win[k][p]), exp_tap(k / W, k % W, p));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_o_valid"}, int'(|bus.o_valid), 0);
        chk({tag, "_o_data"}, int'(|bus.o_data), 0);
        chk({tag, "_i_ready"}, int'(bus.i_ready), 0);
        chk({tag, "_o_done"}, int'(bus.o_done), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        clear_mon();
        feed(1'b0, -1, N);
        wait_done();
        check_frame("plain");

        clear_mon();
        feed(1'b1, -1, N);
        wait_done();
        check_frame("gappy");

        clear_mon();
        feed(1'b0, 6, N);
        wait_done();
        check_frame("restart");

        feed(1'b0, -1, 7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        feed(1'b1, -1, N);
        wait_done();
        check_frame("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
